// File: rtl/fire_pkg.sv
// fire_pkg: shared constants, writer state encoding and RAM address mapping for the fire expand drain.
package fire_pkg;
  localparam int WIDTH = 16;
  localparam int DSP_NO = 128;
  localparam int WOUT = 32;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, DONE} wr_state_t;
  // Channel-major address: channel selects the WOUT^2 page, pixel the word within it.
  function automatic int unsigned map_addr(input int unsigned ch, input int unsigned pix, input int unsigned pw);
    return (ch << pw) | pix;
  endfunction
endpackage

// File: rtl/fire_expand3_ofm_writer_if.sv
// fire_expand3_ofm_writer_if: expand-core sample input and feature-map RAM write port of the writer.
interface fire_expand3_ofm_writer_if #(
  parameter int WIDTH = fire_pkg::WIDTH,
  parameter int DSP_NO = fire_pkg::DSP_NO,
  parameter int AW = 17
);
  logic start;
  logic sample;
  logic [WIDTH-1:0] ofm [DSP_NO];
  logic ram_we;
  logic [AW-1:0] ram_addr;
  logic [WIDTH-1:0] ram_data;
  logic ram_feedback;
  logic busy;
  logic overrun;
  modport master (output start, sample, ofm, input ram_we, ram_addr, ram_data, ram_feedback, busy, overrun);
  modport slave (input start, sample, ofm, output ram_we, ram_addr, ram_data, ram_feedback, busy, overrun);
endinterface

// File: rtl/ofm_capture_buf.sv
// ofm_capture_buf: parallel-load channel bank with a registered indexed read port.
module ofm_capture_buf #(
  parameter int WIDTH = fire_pkg::WIDTH,
  parameter int DSP_NO = fire_pkg::DSP_NO
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [WIDTH-1:0] din [DSP_NO],
  input  logic [$clog2(DSP_NO)-1:0] idx,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] mem [DSP_NO];
  always_ff @(posedge clk) begin
    if (load) mem <= din;
  end
  // Bypass on load so the first word is ready the cycle after capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dout <= '0;
    else dout <= load ? din[idx] : mem[idx];
  end
endmodule

// File: rtl/fire_expand3_ofm_writer.sv
// fire_expand3_ofm_writer: captures each expand output vector and serialises it channel-major into the map RAM.
module fire_expand3_ofm_writer #(
  parameter int WIDTH = fire_pkg::WIDTH,
  parameter int DSP_NO = fire_pkg::DSP_NO,
  parameter int WOUT = fire_pkg::WOUT,
  parameter int SKIP = 1,
  parameter int AW = $clog2(DSP_NO * WOUT * WOUT)
) (
  input logic clk,
  input logic rst,
  fire_expand3_ofm_writer_if.slave bus
);
  import fire_pkg::*;
  localparam int CW = $clog2(DSP_NO);
  localparam int PW = $clog2(WOUT * WOUT);
  localparam int SW = SKIP > 0 ? $clog2(SKIP + 1) : 1;
  wr_state_t state, state_n;
  logic [CW-1:0] ch, ch_n;
  logic [PW-1:0] pix, pix_n;
  logic [SW-1:0] skip_cnt, skip_n;
  logic arm, accept, last_ch, last_pix;
  logic we_n, fb_n, busy_n, ovr_n;
  logic [AW-1:0] addr_n;
  logic [WIDTH-1:0] rd_data;
  assign arm = state == IDLE && bus.start;
  assign accept = state == WAIT && bus.sample && skip_cnt == '0;
  assign last_ch = ch == CW'(DSP_NO - 1);
  assign last_pix = pix == PW'(WOUT * WOUT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.start ? WAIT : IDLE;
      WAIT: state_n = accept ? DRAIN : WAIT;
      DRAIN: state_n = !last_ch ? DRAIN : last_pix ? DONE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are computed from the next state so the registered copies line up with it.
  always_comb begin
    ch_n = (state == DRAIN && !last_ch) ? ch + 1'b1 : '0;
    pix_n = arm ? '0 : (state == DRAIN && last_ch) ? pix + 1'b1 : pix;
    skip_n = arm ? SW'(SKIP) : (state == WAIT && bus.sample && skip_cnt != '0) ? skip_cnt - 1'b1 : skip_cnt;
    we_n = state_n == DRAIN;
    addr_n = we_n ? AW'(map_addr(32'(ch_n), 32'(pix), PW)) : bus.ram_addr;
    fb_n = state_n == DONE;
    busy_n = state_n != IDLE;
    ovr_n = !arm && (bus.overrun || (bus.sample && (state == DRAIN || state == DONE)));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch <= '0;
      pix <= '0;
      skip_cnt <= '0;
      bus.ram_we <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_feedback <= 1'b0;
      bus.busy <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      ch <= ch_n;
      pix <= pix_n;
      skip_cnt <= skip_n;
      bus.ram_we <= we_n;
      bus.ram_addr <= addr_n;
      bus.ram_feedback <= fb_n;
      bus.busy <= busy_n;
      bus.overrun <= ovr_n;
    end
  end
  ofm_capture_buf #(.WIDTH(WIDTH), .DSP_NO(DSP_NO)) u_buf (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .din(bus.ofm),
    .idx(ch_n),
    .dout(rd_data)
  );
  assign bus.ram_data = rd_data;
endmodule

// File: tb/tb_fire_expand3_ofm_writer.sv
// tb_fire_expand3_ofm_writer: randomized scenario bench; a full-size writer plus a reduced one for the full-map run.
module tb_fire_expand3_ofm_writer;
  localparam int W = 16, N = 128, WO = 32, AWD = 17;
  localparam int SN = 16, SWO = 4, SP = SWO * SWO, SAW = 8;
  typedef logic [15:0] vec_t [N];
  typedef logic [15:0] svec_t [SN];
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [31:0] c;} wr_t;
  logic clk = 1'b0, rst = 1'b0;
  int compared = 0, mismatched = 0, cyc = 0;
  wr_t wq[$], eq[$], swq[$];
  int sfb[$], sfall[$];
  logic sb_prev = 1'b0;
  always #5 clk = ~clk;
  fire_expand3_ofm_writer_if #(.WIDTH(W), .DSP_NO(N), .AW(AWD)) bus();
  fire_expand3_ofm_writer_if #(.WIDTH(W), .DSP_NO(SN), .AW(SAW)) sbus();
  fire_expand3_ofm_writer #(.WIDTH(W), .DSP_NO(N), .WOUT(WO), .SKIP(1), .AW(AWD)) dut (.clk(clk), .rst(rst), .bus(bus));
  fire_expand3_ofm_writer #(.WIDTH(W), .DSP_NO(SN), .WOUT(SWO), .SKIP(1), .AW(SAW)) dut_s (.clk(clk), .rst(rst), .bus(sbus));
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.ram_we) wq.push_back('{32'(bus.ram_addr), 32'(bus.ram_data), 32'(cyc)});
    if (sbus.ram_we) swq.push_back('{32'(sbus.ram_addr), 32'(sbus.ram_data), 32'(cyc)});
    if (sbus.ram_feedback) sfb.push_back(cyc);
    if (sb_prev && !sbus.busy) sfall.push_back(cyc);
    sb_prev <= sbus.busy;
  end
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic rand_vec(output vec_t v);
    foreach (v[i]) v[i] = 16'($urandom);
  endtask
  task automatic send(input vec_t v, output int t);
    bus.ofm = v;
    bus.sample = 1'b1;
    t = cyc;
    tick(1);
    bus.sample = 1'b0;
  endtask
  // Reference: a vector accepted in cycle t writes channel c of pixel p at c*WO*WO+p in cycle t+1+c.
  task automatic expect_pixel(input int p, input vec_t v, input int t, input int n);
    for (int c = 0; c < n; c++) eq.push_back('{32'(c * WO * WO + p), 32'(v[c]), 32'(t + 1 + c)});
  endtask
  task automatic test_reset;
    rst = 1'b0;
    tick(3);
    compared++;
    if ({bus.ram_we, bus.ram_feedback, bus.busy, bus.overrun} !== 4'b0) begin
      mismatched++; $display("FAIL reset_flags: got %b want 0000", {bus.ram_we, bus.ram_feedback, bus.busy, bus.overrun});
    end
    compared++;
    if (bus.ram_addr !== '0) begin mismatched++; $display("FAIL reset_addr: got %0d want 0", bus.ram_addr); end
    compared++;
    if (bus.ram_data !== '0) begin mismatched++; $display("FAIL reset_data: got %0h want 0", bus.ram_data); end
    rst = 1'b1;
    tick(2);
  endtask
  task automatic test_skip_first;
    vec_t v;
    int t;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    compared++;
    if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL busy_after_start: got %b want 1", bus.busy); end
    tick(2);
    foreach (v[i]) v[i] = 16'(i + 1);
    send(v, t);
    tick(N + 10);
    compared++;
    if (wq.size() != 0) begin mismatched++; $display("FAIL skipped_sample_writes: got %0d want 0", wq.size()); end
    send(v, t);
    tick(N + 5);
    expect_pixel(0, v, t, N);
    compared++;
    if (wq.size() != eq.size()) begin mismatched++; $display("FAIL first_pixel count: got %0d want %0d", wq.size(), eq.size()); end
    foreach (eq[k]) if (k < wq.size()) begin
      compared++;
      if (wq[k] !== eq[k]) begin mismatched++; $display("FAIL first_pixel[%0d]: got a=%0d d=%0h c=%0d want a=%0d d=%0h c=%0d", k, wq[k].a, wq[k].d, wq[k].c, eq[k].a, eq[k].d, eq[k].c); end
    end
    wq.delete(); eq.delete();
  endtask
  task automatic test_back_to_back;
    vec_t v1, v2;
    int t1, t2;
    rand_vec(v1); rand_vec(v2);
    send(v1, t1);
    tick(N);
    send(v2, t2);
    tick(N + 5);
    expect_pixel(1, v1, t1, N);
    expect_pixel(2, v2, t2, N);
    compared++;
    if (wq.size() != eq.size()) begin mismatched++; $display("FAIL back_to_back count: got %0d want %0d", wq.size(), eq.size()); end
    foreach (eq[k]) if (k < wq.size()) begin
      compared++;
      if (wq[k] !== eq[k]) begin mismatched++; $display("FAIL back_to_back[%0d]: got a=%0d d=%0h c=%0d want a=%0d d=%0h c=%0d", k, wq[k].a, wq[k].d, wq[k].c, eq[k].a, eq[k].d, eq[k].c); end
    end
    compared++;
    if (bus.overrun !== 1'b0) begin mismatched++; $display("FAIL back_to_back_overrun: got %b want 0", bus.overrun); end
    wq.delete(); eq.delete();
  endtask
  task automatic test_start_in_wait;
    vec_t v;
    int t;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    compared++;
    if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL start_in_wait_busy: got %b want 1", bus.busy); end
    rand_vec(v);
    send(v, t);
    tick(N + 5);
    expect_pixel(3, v, t, N);
    compared++;
    if (wq.size() != eq.size()) begin mismatched++; $display("FAIL start_in_wait count: got %0d want %0d", wq.size(), eq.size()); end
    foreach (eq[k]) if (k < wq.size()) begin
      compared++;
      if (wq[k] !== eq[k]) begin mismatched++; $display("FAIL start_in_wait[%0d]: got a=%0d d=%0h c=%0d want a=%0d d=%0h c=%0d", k, wq[k].a, wq[k].d, wq[k].c, eq[k].a, eq[k].d, eq[k].c); end
    end
    wq.delete(); eq.delete();
  endtask
  task automatic test_overrun;
    vec_t v1, v2;
    int t1, t2;
    rand_vec(v1); rand_vec(v2);
    send(v1, t1);
    tick(39);
    send(v2, t2);
    tick(2);
    compared++;
    if (bus.overrun !== 1'b1) begin mismatched++; $display("FAIL overrun_set: got %b want 1", bus.overrun); end
    tick(N + 5);
    expect_pixel(4, v1, t1, N);
    compared++;
    if (wq.size() != eq.size()) begin mismatched++; $display("FAIL overrun_writes count: got %0d want %0d", wq.size(), eq.size()); end
    foreach (eq[k]) if (k < wq.size()) begin
      compared++;
      if (wq[k] !== eq[k]) begin mismatched++; $display("FAIL overrun_writes[%0d]: got a=%0d d=%0h c=%0d want a=%0d d=%0h c=%0d", k, wq[k].a, wq[k].d, wq[k].c, eq[k].a, eq[k].d, eq[k].c); end
    end
    compared++;
    if (bus.overrun !== 1'b1) begin mismatched++; $display("FAIL overrun_sticky: got %b want 1", bus.overrun); end
    wq.delete(); eq.delete();
  endtask
  task automatic test_reset_mid_drain;
    vec_t v;
    int t;
    rand_vec(v);
    send(v, t);
    tick(60);
    rst = 1'b0;
    tick(1);
    compared++;
    if ({bus.ram_we, bus.ram_feedback, bus.busy, bus.overrun} !== 4'b0 || bus.ram_addr !== '0 || bus.ram_data !== '0) begin
      mismatched++;
      $display("FAIL mid_reset_outputs: got we/fb/busy/ovr=%b addr=%0d data=%0h want 0000 0 0", {bus.ram_we, bus.ram_feedback, bus.busy, bus.overrun}, bus.ram_addr, bus.ram_data);
    end
    expect_pixel(5, v, t, 60);
    compared++;
    if (wq.size() != eq.size()) begin mismatched++; $display("FAIL mid_reset_partial count: got %0d want %0d", wq.size(), eq.size()); end
    foreach (eq[k]) if (k < wq.size()) begin
      compared++;
      if (wq[k] !== eq[k]) begin mismatched++; $display("FAIL mid_reset_partial[%0d]: got a=%0d d=%0h c=%0d want a=%0d d=%0h c=%0d", k, wq[k].a, wq[k].d, wq[k].c, eq[k].a, eq[k].d, eq[k].c); end
    end
    rst = 1'b1;
    tick(2);
    wq.delete(); eq.delete();
  endtask
  task automatic test_start_and_sample;
    vec_t v1, v2;
    int t;
    rand_vec(v1); rand_vec(v2);
    bus.sample = 1'b1;
    tick(1);
    bus.sample = 1'b0;
    compared++;
    if (bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin mismatched++; $display("FAIL idle_sample: got busy=%b ovr=%b want 0 0", bus.busy, bus.overrun); end
    bus.ofm = v1;
    bus.start = 1'b1;
    bus.sample = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.sample = 1'b0;
    compared++;
    if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL start_sample_busy: got %b want 1", bus.busy); end
    send(v1, t);
    tick(N + 5);
    compared++;
    if (wq.size() != 0) begin mismatched++; $display("FAIL start_sample_skip: got %0d writes want 0", wq.size()); end
    send(v2, t);
    tick(N + 5);
    expect_pixel(0, v2, t, N);
    compared++;
    if (wq.size() != eq.size()) begin mismatched++; $display("FAIL restart count: got %0d want %0d", wq.size(), eq.size()); end
    foreach (eq[k]) if (k < wq.size()) begin
      compared++;
      if (wq[k] !== eq[k]) begin mismatched++; $display("FAIL restart[%0d]: got a=%0d d=%0h c=%0d want a=%0d d=%0h c=%0d", k, wq[k].a, wq[k].d, wq[k].c, eq[k].a, eq[k].d, eq[k].c); end
    end
    wq.delete(); eq.delete();
  endtask
  task automatic test_full_map;
    svec_t v;
    int t;
    int cnt [SN * SP];
    logic [15:0] mem [SN * SP];
    foreach (cnt[a]) begin cnt[a] = 0; mem[a] = '0; end
    sbus.start = 1'b1;
    tick(1);
    sbus.start = 1'b0;
    for (int p = -1; p < SP; p++) begin
      foreach (v[i]) v[i] = (p < 0) ? 16'($urandom) : 16'(p * SN + i);
      sbus.ofm = v;
      sbus.sample = 1'b1;
      t = cyc;
      tick(1);
      sbus.sample = 1'b0;
      if (p == 0) begin
        tick(3);
        foreach (sbus.ofm[i]) sbus.ofm[i] = 16'($urandom);
        sbus.sample = 1'b1;
        tick(1);
        sbus.sample = 1'b0;
      end
      tick($urandom_range(SN, SN + 6));
    end
    tick(6);
    foreach (swq[k]) if (swq[k].a < SN * SP) begin
      mem[swq[k].a] = swq[k].d[15:0];
      cnt[swq[k].a]++;
    end
    compared++;
    if (swq.size() != SN * SP) begin mismatched++; $display("FAIL full_map count: got %0d want %0d", swq.size(), SN * SP); end
    foreach (mem[a]) begin
      compared++;
      if (cnt[a] != 1 || mem[a] !== 16'((a % SP) * SN + a / SP)) begin
        mismatched++; $display("FAIL full_map word %0d: got %0h x%0d want %0h x1", a, mem[a], cnt[a], 16'((a % SP) * SN + a / SP));
      end
    end
    compared++;
    if (sfb.size() != 1 || sfb[0] != t + SN + 1) begin mismatched++; $display("FAIL feedback: got %0d pulses first@%0d want 1 @%0d", sfb.size(), sfb.size() ? sfb[0] : -1, t + SN + 1); end
    compared++;
    if (sfall.size() != 1 || sfall[0] != t + SN + 2) begin mismatched++; $display("FAIL busy_fall: got %0d falls first@%0d want 1 @%0d", sfall.size(), sfall.size() ? sfall[0] : -1, t + SN + 2); end
    compared++;
    if (sbus.overrun !== 1'b1) begin mismatched++; $display("FAIL map_overrun: got %b want 1", sbus.overrun); end
    sbus.start = 1'b1;
    tick(1);
    sbus.start = 1'b0;
    compared++;
    if (sbus.overrun !== 1'b0 || sbus.busy !== 1'b1) begin mismatched++; $display("FAIL start_clears_overrun: got ovr=%b busy=%b want 0 1", sbus.overrun, sbus.busy); end
  endtask
  initial begin
    bus.start = 1'b0; bus.sample = 1'b0;
    sbus.start = 1'b0; sbus.sample = 1'b0;
    foreach (bus.ofm[i]) bus.ofm[i] = '0;
    foreach (sbus.ofm[i]) sbus.ofm[i] = '0;
    test_reset;
    test_skip_first;
    test_back_to_back;
    test_start_in_wait;
    test_overrun;
    test_reset_mid_drain;
    test_start_and_sample;
    test_full_map;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fire_expand3_ofm_writer.md
# fire_expand3_ofm_writer

Downstream drain stage for the fire4/fire5 3×3 expand layer. It captures the 128-channel output vector that the expand core presents on each sample pulse and serialises it into the feature-map RAM, one 16-bit word per cycle, in channel-major order. When a full 32×32 map is written it pulses `ram_feedback`, which the expand core uses to clear its finish flag.

## Interface
Parameters:
- `WIDTH`, 16, word width of each output channel.
- `DSP_NO`, 128, number of channels per sample.
- `WOUT`, 32, output map side; the map holds WOUT² pixels.
- `SKIP`, 1, number of leading sample pulses discarded after `start` (pipeline warm-up).
- `AW`, $clog2(DSP_NO*WOUT**2) = 17, RAM address width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; arms the writer for one layer.
- `sample`  in  1  high for the cycle in which `ofm` holds a new vector.
- `ofm`  in  WIDTH×[0:DSP_NO-1]  unpacked array of channel results.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  AW  write address, ch·WOUT² + pix.
- `ram_data`  out  WIDTH  write data.
- `ram_feedback`  out  1  one-cycle pulse after the last word of the map is written.
- `busy`  out  1  high in every state except IDLE.
- `overrun`  out  1  sticky; set when a sample is lost.

## Operation
- States:
  - IDLE: waits for `start`.
  - WAIT: waits for `sample`.
  - DRAIN: writes DSP_NO words.
  - DONE: one cycle, pulses `ram_feedback`.
- IDLE → WAIT on `start`:
  - clear `pix` and `ch`.
  - load `skip_cnt` = SKIP.
  - clear `overrun`.
- WAIT on `sample`:
  - If `skip_cnt` ≠ 0, decrement it and stay in WAIT. No capture.
  - Otherwise, load all DSP_NO `ofm` words into the capture buffer, set `ch` = 0, go to DRAIN.
- DRAIN, each cycle:
  - `ram_we` = 1, `ram_data` = buf[ch], `ram_addr` = ch·WOUT² + pix.
  - `ch` increments each cycle.
  - At `ch` = DSP_NO-1: reset `ch` to 0 and increment `pix`. If `pix` = WOUT²-1, go to DONE; otherwise go to WAIT.
- DONE: `ram_feedback` = 1 for one cycle, then go to IDLE.
- Address arithmetic: `ch` is shifted left by log2(WOUT²), then OR'd with `pix`. No multiplier. WOUT² must be a power of two.
- Boundary rules:
  - `sample` during DRAIN or DONE: ignored, `overrun` ← 1 and held until the next `start` or reset. The buffer is not disturbed.
  - `sample` in IDLE: ignored, no flag.
  - `start` when not IDLE: ignored.
  - `start` and `sample` in the same IDLE cycle: `start` wins; that sample is not counted.
  - Reset mid-operation: immediate return to IDLE, and all outputs reset. Partial RAM contents are left as written.

## Timing
- Reset values: `ram_we` 0, `ram_addr` 0, `ram_data` 0, `ram_feedback` 0, `busy` 0, `overrun` 0. The buffer contents are don't-care.
- All outputs are registered.
- `sample` is high in cycle t (accepted in WAIT):
  - The buffer loads at the end of t.
  - `ram_we` is high in cycles t+1 … t+DSP_NO, with channel 0 first.
  - The writer returns to WAIT in cycle t+DSP_NO+1 and can accept `sample` in that cycle.
- Minimum sample spacing is DSP_NO+1 cycles. The expand core's period of 9·32+1 = 289 cycles satisfies this.
- After the last pixel's final write in cycle t+DSP_NO:
  - `ram_feedback` is high in cycle t+DSP_NO+1.
  - `busy` is low from cycle t+DSP_NO+2.
- `busy` rises the cycle after `start`.

## Structure
- Shared package `fire_pkg`:
  - constants WIDTH, DSP_NO, WOUT.
  - `wr_state_t` enum {IDLE, WAIT, DRAIN, DONE}.
  - function `map_addr(ch, pix)`.
- Sub-module `ofm_capture_buf`:
  - DSP_NO×WIDTH register bank.
  - parallel load on `load`.
  - registered indexed read by `ch`.
- The top level holds the FSM, counters and flags (target ~200 lines total).

## Test plan
- Reset, then `start`, then SKIP+1 samples with ofm[i] = i+1: the first sample produces no writes. The second gives 128 writes at addresses 0, 1024, …, 130048 with data 1…128; `ram_we` is high for exactly 128 cycles starting one cycle after `sample`.
- Full map: 1 + 1024 samples spaced 289 cycles, ofm[i] = pix·128 + i (mod 2¹⁶). Scoreboard checks all 131072 RAM words. `ram_feedback` pulses once, one cycle after the write to address 131071; `busy` falls the next cycle.
- Overrun: `sample` 40 cycles after an accepted sample. `overrun` rises and stays high, the writes still carry the original vector, and the next `start` clears `overrun`.
- Back-to-back: a sample exactly 129 cycles after the previous one is accepted, with no gap in the address sequence and `overrun` staying 0.
- Reset mid-DRAIN at channel 60: all outputs are 0 the next cycle and the state is IDLE. A new `start` restarts from pixel 0, channel 0.
- `start` during WAIT and a simultaneous `start`+`sample` in IDLE: both follow the boundary rules in Operation; pix/ch counters are unchanged by the ignored `start`.
